// File: rtl/fp_add_pkg.sv
// Shared types and constants for the floating-point adder sequencer.
// State encoding plus default datapath widths.
package fp_add_pkg;

  localparam int EXP_W     = 8;
  localparam int MANT_W    = 24;
  localparam int CNT_W     = 5;
  localparam int MAX_SHIFT = MANT_W + 1;
  localparam int EXP_MAX   = 2**EXP_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALIGN,
    ADD,
    NORM,
    FIN
  } state_t;

endpackage

// File: rtl/fp_exp_compare.sv
// Exponent comparator: operand swap, larger exponent and clamped alignment shift.
// Purely combinational; no backpressure.
module fp_exp_compare
  import fp_add_pkg::*;
#(
  parameter int EXP_W  = fp_add_pkg::EXP_W,
  parameter int MANT_W = fp_add_pkg::MANT_W,
  parameter int CNT_W  = fp_add_pkg::CNT_W
) (
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  output logic             swap,
  output logic [EXP_W-1:0] exp_max,
  output logic [CNT_W-1:0] shift_amt
);

  localparam logic [EXP_W-1:0] SHIFT_CAP = EXP_W'(MANT_W + 1);

  logic [EXP_W-1:0] diff;

  assign swap    = exp_b > exp_a;
  assign exp_max = swap ? exp_b : exp_a;
  assign diff    = swap ? (exp_b - exp_a) : (exp_a - exp_b);

  // Shifting past the full mantissa plus guard position flushes the operand,
  // so anything larger saturates to that amount.
  assign shift_amt = (diff > SHIFT_CAP) ? CNT_W'(MANT_W + 1) : diff[CNT_W-1:0];

endmodule

// File: rtl/fp_add_sequencer.sv
// Control FSM for the FP adder: align, add, normalize, exponent tracking.
// Latency 5 + shifts + left-normalizations; start ignored while busy. Option: STICKY_BIT_EN.
module fp_add_sequencer
  import fp_add_pkg::*;
#(
  parameter int EXP_W  = fp_add_pkg::EXP_W,
  parameter int MANT_W = fp_add_pkg::MANT_W,
  parameter int CNT_W  = fp_add_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             cnt_zero,
  input  logic             shifted_out_bit,
  input  logic             mant_carry,
  input  logic             mant_msb,
  input  logic             mant_zero,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_value,
  output logic             swap,
  output logic             align_shift,
  output logic             add_en,
  output logic             norm_right,
  output logic             norm_left,
  output logic [EXP_W-1:0] exp_res,
  output logic             sticky,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             unf
);

  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
  localparam logic [EXP_W-1:0] EXP_SATM = EXP_ALL1 - EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_t           state_q, state_d;
  logic             swap_q;
  logic [CNT_W-1:0] shift_q;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             cmp_swap;
  logic [EXP_W-1:0] cmp_max;
  logic [CNT_W-1:0] cmp_shift;
  logic             accept;

  fp_exp_compare #(
    .EXP_W (EXP_W),
    .MANT_W(MANT_W),
    .CNT_W (CNT_W)
  ) u_cmp (
    .exp_a    (exp_a),
    .exp_b    (exp_b),
    .swap     (cmp_swap),
    .exp_max  (cmp_max),
    .shift_amt(cmp_shift)
  );

  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      swap_q  <= 1'b0;
      shift_q <= '0;
      exp_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (accept) begin
        swap_q  <= cmp_swap;
        shift_q <= cmp_shift;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    cnt_load    = 1'b0;
    align_shift = 1'b0;
    add_en      = 1'b0;
    norm_right  = 1'b0;
    norm_left   = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          exp_d   = cmp_max;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      LOAD: begin
        cnt_load = 1'b1;
        state_d  = ALIGN;
      end
      ALIGN: begin
        if (!cnt_zero) align_shift = 1'b1;
        else           state_d     = ADD;
      end
      ADD: begin
        add_en  = 1'b1;
        state_d = NORM;
      end
      NORM: begin
        if (mant_zero) begin
          exp_d   = '0;
          unf_d   = 1'b0;
          state_d = FIN;
        end else if (mant_carry) begin
          norm_right = 1'b1;
          if (exp_q == EXP_SATM) begin
            exp_d = EXP_ALL1;
            ovf_d = 1'b1;
          end else begin
            exp_d = exp_q + EXP_ONE;
          end
          state_d = FIN;
        end else if (!mant_msb && (exp_q > EXP_ONE)) begin
          norm_left = 1'b1;
          exp_d     = exp_q - EXP_ONE;
        end else if (!mant_msb) begin
          // Cannot shift left without going subnormal: flush to zero.
          unf_d   = 1'b1;
          exp_d   = '0;
          state_d = FIN;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_value = (state_q == LOAD) ? shift_q : '0;
  assign swap      = swap_q;
  assign exp_res   = exp_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign busy      = (state_q != IDLE);

`ifdef STICKY_BIT_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           sticky_q <= 1'b0;
    else if (accept)                      sticky_q <= 1'b0;
    else if (align_shift && shifted_out_bit) sticky_q <= 1'b1;
  end

  assign sticky = sticky_q;
`else
  logic unused_shifted_out_bit;
  assign unused_shifted_out_bit = shifted_out_bit;
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer with a behavioural counter/mantissa model.
module tb_fp_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] exp_a = '0, exp_b = '0;
  logic       cnt_zero = 1'b1, shifted_out_bit = 1'b0;
  logic       mant_carry = 1'b0, mant_msb = 1'b1, mant_zero = 1'b0;
  logic       cnt_load, swap, align_shift, add_en, norm_right, norm_left;
  logic [4:0] cnt_value;
  logic [7:0] exp_res;
  logic       sticky, busy, done, ovf, unf;

  fp_add_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_a(exp_a), .exp_b(exp_b),
    .cnt_zero(cnt_zero), .shifted_out_bit(shifted_out_bit), .mant_carry(mant_carry),
    .mant_msb(mant_msb), .mant_zero(mant_zero), .cnt_load(cnt_load), .cnt_value(cnt_value),
    .swap(swap), .align_shift(align_shift), .add_en(add_en), .norm_right(norm_right),
    .norm_left(norm_left), .exp_res(exp_res), .sticky(sticky), .busy(busy), .done(done),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int swp, cv, er, ovf, unf, stk, lat, s, l, r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0, dones = 0, issued = 0;

  // Per-operation datapath scenario
  int          k_cur = 0;
  logic [24:0] sb_cur = '0;
  int          dp_cnt = 0, dp_lefts = 0, dp_idx = 0;
  int          pend_load = 0, pend_val = 0, pend_shift = 0, pend_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t model(int a, int b, bit z, bit c, int k, logic [24:0] sb);
    exp_t m;
    int e, d, maxl;
    m.swp = (b > a) ? 1 : 0;
    e = (a > b) ? a : b;
    d = (a > b) ? a - b : b - a;
    m.s = (d > 25) ? 25 : d;
    m.cv = m.s;
    m.stk = 0;
`ifdef STICKY_BIT_EN
    for (int i = 0; i < m.s; i++) if (sb[i]) m.stk = 1;
`endif
    m.ovf = 0; m.unf = 0; m.l = 0; m.r = 0;
    if (z) begin
      m.er = 0;
    end else if (c) begin
      m.r = 1;
      if (e == 254) begin m.er = 255; m.ovf = 1; end
      else m.er = (e + 1) % 256;
    end else begin
      maxl = (e >= 1) ? e - 1 : 0;
      if (k <= maxl) begin m.l = k; m.er = e - k; end
      else begin m.l = maxl; m.er = 0; m.unf = 1; end
    end
    m.lat = 5 + m.s + m.l;
    return m;
  endfunction

  // Datapath model: alignment down counter and result mantissa MSB
  initial begin
    forever begin
      @(posedge clk); #2;
      if (pend_load != 0) dp_cnt = pend_val; else dp_cnt = dp_cnt - pend_shift;
      dp_lefts += pend_left;
      dp_idx   += pend_shift;
      cnt_zero = (dp_cnt == 0);
      mant_msb = (dp_lefts >= k_cur);
      shifted_out_bit = (dp_idx < 25) ? sb_cur[dp_idx] : 1'b0;
      @(negedge clk); #1;
      pend_load  = cnt_load ? 1 : 0;
      pend_val   = int'(cnt_value);
      pend_shift = align_shift ? 1 : 0;
      pend_left  = norm_left ? 1 : 0;
    end
  end

  // Monitor: observes the handshake and scores each done against the queue
  initial begin
    int cyc = 0, loads = 0, lval = 0, shifts = 0, lefts = 0, rights = 0, adds = 0;
    bit in_op = 0, excl_bad = 0;
    exp_t m;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        in_op = 0;
      end else begin
        if (start && !busy) begin
          in_op = 1; cyc = 0; loads = 0; lval = 0; shifts = 0;
          lefts = 0; rights = 0; adds = 0; excl_bad = 0;
        end else if (in_op) begin
          cyc++;
        end
        if ($countones({cnt_load, align_shift, add_en, norm_right, norm_left}) > 1) excl_bad = 1;
        if (cnt_load) begin loads++; lval = int'(cnt_value); end
        if (align_shift) shifts++;
        if (norm_left)   lefts++;
        if (norm_right)  rights++;
        if (add_en)      adds++;
        if (done) begin
          dones++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            m = exp_q.pop_front();
            chk("latency", cyc, m.lat);
            chk("exp_res", exp_res, m.er);
            chk("swap", swap, m.swp);
            chk("ovf", ovf, m.ovf);
            chk("unf", unf, m.unf);
            chk("sticky", sticky, m.stk);
            chk("cnt_value", lval, m.cv);
            chk("cnt_load_count", loads, 1);
            chk("add_count", adds, 1);
            chk("align_shifts", shifts, m.s);
            chk("norm_left_count", lefts, m.l);
            chk("norm_right_count", rights, m.r);
            chk("exclusive_strobes", excl_bad, 0);
          end
          in_op = 0;
        end
      end
    end
  end

  task automatic launch(int a, int b, bit z, bit c, int k, logic [24:0] sb);
    @(posedge clk); #1;
    exp_a = 8'(a); exp_b = 8'(b); mant_zero = z; mant_carry = c;
    k_cur = k; sb_cur = sb; dp_lefts = 0; dp_idx = 0;
    exp_q.push_back(model(a, b, z, c, k, sb));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(int a, int b, bit z, bit c, int k, logic [24:0] sb, bit poke);
    int d0;
    d0 = dones;
    launch(a, b, z, c, k, sb);
    issued++;
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; exp_a = 8'd0; exp_b = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 600 && dones == d0; i++) @(posedge clk);
    if (dones == d0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=0 required=1");
      exp_q.delete();
    end
  endtask

  initial begin
    int a, b, k;
    bit z, c;
    logic [24:0] sb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {cnt_load, cnt_value, swap, align_shift, add_en, norm_right,
                          norm_left, exp_res, sticky, busy, done, ovf, unf}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(130, 127, 0, 0, 0, '0, 0);
    run_op(100, 100, 0, 1, 0, '0, 0);
    run_op(10, 200, 0, 0, 0, 25'h1555555, 0);
    run_op(50, 50, 0, 0, 3, '0, 0);
    run_op(2, 2, 0, 0, 1000, '0, 0);
    run_op(254, 250, 0, 1, 0, '0, 1);
    run_op(103, 100, 0, 0, 0, 25'b010, 0);
    run_op(80, 70, 1, 0, 0, '1, 0);
    run_op(0, 0, 0, 0, 1, '0, 0);

    // Reset while aligning: operation is abandoned with no done
    launch(10, 200, 0, 0, 0, '0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_align", {cnt_load, cnt_value, swap, align_shift, add_en, norm_right,
                            norm_left, exp_res, sticky, busy, done, ovf, unf}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a = dones;
    repeat (40) @(posedge clk);
    chk("no_done_after_reset", dones, a);

    for (int n = 0; n < 40; n++) begin
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 255);
      z  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 3) == 0);
      k  = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 4);
      sb = 25'($urandom);
      run_op(a, b, z, c, k, sb, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    chk("op_count", dones, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Control FSM for the 32-bit floating-point adder datapath.
- Per operation:
  - compares exponents, selects the operand swap, and loads the 5-bit alignment down counter with the clamped shift amount;
  - drives one right-shift of the smaller mantissa per cycle until the counter reports zero;
  - fires the mantissa add, then runs the normalization loop while tracking the result exponent.
- Sits between the operand registers and the shifter/adder/normalizer datapath.

Parameters:
- EXP_W, 8, exponent width.
- MANT_W, 24, mantissa width including hidden bit.
- CNT_W, 5, alignment counter width. Requires MANT_W+1 <= 2**CNT_W-1.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- exp_a  in  EXP_W  exponent of operand A.
- exp_b  in  EXP_W  exponent of operand B.
- cnt_zero  in  1  zero-detect from the alignment down counter; high when its count is 0.
- shifted_out_bit  in  1  LSB leaving the aligning mantissa this cycle.
- mant_carry  in  1  adder carry-out, valid from the NORM state.
- mant_msb  in  1  MSB of the result mantissa register.
- mant_zero  in  1  result mantissa is all-zero.
- cnt_load  out  1  load strobe to the counter.
- cnt_value  out  CNT_W  shift amount to load.
- swap  out  1  1 means B has the larger exponent; datapath aligns A.
- align_shift  out  1  right-shift the smaller mantissa this cycle.
- add_en  out  1  capture the adder result this cycle.
- norm_right  out  1  shift the result right 1 (carry case).
- norm_left  out  1  shift the result left 1.
- exp_res  out  EXP_W  result exponent.
- sticky  out  1  OR of shifted-out bits (see Optional Feature).
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- ovf  out  1  exponent overflow flag, valid with done.
- unf  out  1  underflow/flush flag, valid with done.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE;
  - every output 0, including exp_res;
  - internal registers cleared.
  - Reset mid-operation abandons the operation; no done pulse is issued.
- States: IDLE, LOAD, ALIGN, ADD, NORM, FIN.
- IDLE:
  - On start=1: latch swap=(exp_b>exp_a), exp_res=max(exp_a,exp_b), diff=|exp_a-exp_b|.
  - Next state LOAD.
  - start while busy is ignored.
- LOAD:
  - cnt_load=1 for exactly one cycle.
  - cnt_value=min(diff, MANT_W+1); diff >= 25 saturates to 25, fully flushing the smaller operand.
  - Next state ALIGN.
- ALIGN:
  - If cnt_zero=0: align_shift=1; the counter decrements in the same cycle.
  - If cnt_zero=1: align_shift=0, next state ADD.
  - Exactly cnt_value align_shift cycles occur. Loaded value 0 gives zero shifts and one ALIGN cycle.
- ADD: add_en=1 for one cycle; next state NORM.
- NORM, evaluated each cycle in priority order:
  1. mant_zero=1: exp_res:=0, unf=0, go FIN.
  2. mant_carry=1: norm_right=1 once. If exp_res==2**EXP_W-2, exp_res:=2**EXP_W-1 and ovf:=1; otherwise exp_res+1. Go FIN.
  3. mant_msb=0 and exp_res>1: norm_left=1, exp_res-1, stay in NORM.
  4. mant_msb=0 and exp_res<=1: unf:=1, exp_res:=0, go FIN.
  5. Otherwise (normalized): go FIN.
- FIN:
  - done=1 for one cycle; next state IDLE.
  - exp_res, ovf, unf and sticky hold until the next accepted start, which clears ovf, unf and sticky.
- Latency: done is asserted 5 + S + L cycles after the start cycle.
  - S = loaded shift amount.
  - L = number of norm_left cycles.
- No two of cnt_load, align_shift, add_en, norm_right, norm_left are ever high together.

Optional Feature:
- Macro STICKY_BIT_EN.
- Defined: sticky is set whenever align_shift=1 and shifted_out_bit=1. It is cleared at start acceptance and holds through FIN.
- Not defined: sticky is constant 0 and shifted_out_bit is unused.

Decomposition:
- Shared package fp_add_pkg holds:
  - the state enum (IDLE, LOAD, ALIGN, ADD, NORM, FIN);
  - EXP_W, MANT_W, CNT_W constants;
  - MAX_SHIFT=MANT_W+1;
  - EXP_MAX=2**EXP_W-1.
- Sub-module fp_exp_compare (combinational): computes swap, max exponent, and the clamped diff.
- The FSM and exponent update stay in fp_add_sequencer.

Test Plan:
- exp_a=130, exp_b=127, msb=1 after add, counter modelled → cnt_value=3, swap=0, three align_shift cycles, done 8 cycles after start, exp_res=130.
- exp_a=exp_b=100, mant_carry=1 → cnt_value=0, no align_shift, one norm_right, exp_res=101, done at start+5.
- exp_a=10, exp_b=200 → swap=1, cnt_value=25 (saturated), 25 align_shift cycles, exp_res=200.
- Equal exponents, result msb=0 for 3 cycles then 1, exp=50 → three norm_left, exp_res=47; second case with exp=2 and msb stuck 0 → one norm_left, then unf=1, exp_res=0.
- exp_a=254, mant_carry=1 → exp_res=255, ovf=1; start pulsed during busy is ignored.
- Rst_n low during ALIGN → all outputs 0 immediately, no done. With STICKY_BIT_EN, shifted_out_bit=1 on the 2nd of 3 shifts → sticky=1 at done; without the macro sticky=0.
